ultrasonic_ranger: RTL
======================

# ultrasonic_ranger

Avalon-MM slave front end for an HC-SR04-style ultrasonic sensor. It fires periodic trigger pulses, measures the echo pulse width in clock cycles and publishes the latest result at register address 0 (`SONIC_REG`, bits 21:0), where the obstacle-avoidance master polls it. It sits between the sensor GPIO pins and the bus consumed by the motion-control logic.

## Interface
- TRIG_CYCLES, 500: trigger high time in clk cycles (10 µs at 50 MHz).
- TIMEOUT_CYCLES, 1_500_000: maximum wait for echo rising edge after trigger falls.
- DEFAULT_PERIOD, 3_000_000: reset value of PERIOD register (60 ms at 50 MHz).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; all state to reset values.
- s_cs  in  1  chip select; a bus access happens only when high.
- s_read  in  1  read strobe, qualified by s_cs.
- s_write  in  1  write strobe, qualified by s_cs.
- s_address  in  3  register word address.
- s_writedata  in  32  write data.
- s_readdata  out  32  read data, registered.
- trig  out  1  sensor trigger.
- echo  in  1  sensor echo, asynchronous; 2-flop synchronized before use.

## Operation
- Register map:
  - 0 DIST (RO): [21:0] last width, [29:22] 0, [30] NEW, [31] TIMEOUT.
  - 1 CTRL (RW): [0] ENABLE (reset 1), [1] START (write-1 pulse, reads 0).
  - 2 PERIOD (RW): [23:0] cycles between trigger starts; [31:24] read 0.
  - 3 COUNT (RO): [15:0] completed measurements, wraps 0xFFFF→0.
  - 4–7: read 0, writes ignored. Writes to RO registers are ignored.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
  - IDLE → TRIG when ENABLE and period counter ≥ PERIOD, or START written; period counter clears on entering TRIG.
  - TRIG: trig=1 for exactly TRIG_CYCLES cycles → WAIT_RISE.
  - WAIT_RISE: on synchronized echo rising edge → MEASURE with width counter = 0; if TIMEOUT_CYCLES elapse → HOLDOFF with DIST[21:0]=0x3FFFFF, TIMEOUT=1.
  - MEASURE: width counter +1 per cycle while echo high; on falling edge → HOLDOFF, DIST[21:0]=counter, TIMEOUT=0. Counter saturates at 0x3FFFFF; reaching it → HOLDOFF with DIST=0x3FFFFF, TIMEOUT=1.
  - HOLDOFF: NEW=1, COUNT+1 (one cycle) → IDLE.
- Period counter (24 bit) runs free in all states, saturating at 0xFFFFFF; PERIOD=0 behaves as back-to-back triggers.
- ENABLE cleared mid-measurement: current measurement completes; no new automatic trigger.
- START while not IDLE: ignored.
- NEW clears on a read of address 0; if HOLDOFF sets NEW in the same cycle as that read, set wins (read returns old value with old NEW).
- DIST holds previous value until a measurement completes; never shows partial counts.

## Timing
- Reset values: s_readdata=0, trig=0, DIST=0, CTRL=0x1, PERIOD=DEFAULT_PERIOD, COUNT=0, state IDLE, counters 0.
- Read latency 1: s_readdata valid the cycle after s_cs&s_read; holds until next read. No wait states.
- Write takes effect the cycle after s_cs&s_write.
- Simultaneous s_read and s_write: write performed, read ignored.
- Echo path latency: 2 sync cycles + 1 edge-detect cycle; measured width equals echo high time in cycles (±1).
- Trigger-to-NEW: TRIG_CYCLES + rise wait + width + 4 cycles max.
- reset asserted mid-measurement: trig drops immediately (asynchronous), FSM to IDLE, registers to reset values.

## Test plan
- Reset then idle: after reset release, trig stays 0 until PERIOD (DEFAULT_PERIOD) cycles elapse; read addr 1 → 0x00000001, addr 2 → 0x002DC6C0.
- Nominal echo: PERIOD=2000, echo high 5000 cycles starting 100 cycles after trig falls → trig high exactly 500 cycles; read addr 0 → 0x40000000|5000 (±1); second read → NEW=0; addr 3 → 1.
- No echo: echo held 0 → after 1_500_000 cycles DIST reads 0xC03FFFFF.
- Saturation: echo held high > 0x3FFFFF cycles → DIST=0xC03FFFFF, FSM returns IDLE, next trigger issued.
- Single-shot: write CTRL=0x2 (ENABLE=0) → one trig pulse, echo 1200 cycles → DIST[21:0]=1200, no further triggers over 10×PERIOD.
- Reset mid-MEASURE and unused addresses: assert reset during echo → trig=0, DIST=0; reads of addresses 4–7 → 0; write to addr 0 leaves DIST unchanged.

Source files
------------

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic/one-shot trigger, echo width capture, Avalon-MM register view.
// Reads return one cycle after s_cs&s_read; no wait states; writes land the following cycle.
module ultrasonic_ranger #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
    parameter int unsigned DEFAULT_PERIOD = 3_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_cs,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [2:0]  s_address,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        trig,
    input  logic        echo
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

    localparam logic [21:0] W_MAX     = 22'h3FFFFF;
    localparam logic [23:0] P_MAX     = 24'hFFFFFF;
    localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_cnt;
    logic [21:0] r_width;
    logic [23:0] r_pcnt;
    logic [23:0] r_period;
    logic        r_enable, r_start;
    logic [21:0] r_dist;
    logic        r_tmo, r_new;
    logic [15:0] r_count;
    logic [31:0] r_readdata;
    logic        r_echo_meta, r_echo_sync, r_echo_prev;

    logic        w_bus_wr, w_bus_rd, w_rise, w_fall;
    logic        w_done, w_done_tmo;
    logic [21:0] w_done_width;
    logic        w_unused;

    assign w_bus_wr   = s_cs & s_write;
    assign w_bus_rd   = s_cs & s_read & ~s_write;
    assign w_rise     = r_echo_sync & ~r_echo_prev;
    assign w_fall     = ~r_echo_sync & r_echo_prev;
    assign trig       = (r_state == TRIG);
    assign s_readdata = r_readdata;
    assign w_unused   = ^s_writedata[31:24];

    always_comb begin
        w_state_nxt  = r_state;
        w_done       = 1'b0;
        w_done_tmo   = 1'b0;
        w_done_width = r_width;
        case (r_state)
            IDLE: begin
                if (r_start || (r_enable && (r_pcnt >= r_period)))
                    w_state_nxt = TRIG;
            end
            TRIG: begin
                if (r_cnt == TRIG_LAST)
                    w_state_nxt = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (w_rise) begin
                    w_state_nxt = MEASURE;
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt  = HOLDOFF;
                    w_done       = 1'b1;
                    w_done_tmo   = 1'b1;
                    w_done_width = W_MAX;
                end
            end
            MEASURE: begin
                if (w_fall) begin
                    w_state_nxt = HOLDOFF;
                    w_done      = 1'b1;
                end else if (r_width == W_MAX) begin
                    w_state_nxt  = HOLDOFF;
                    w_done       = 1'b1;
                    w_done_tmo   = 1'b1;
                    w_done_width = W_MAX;
                end
            end
            HOLDOFF: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_echo_meta <= 1'b0;
            r_echo_sync <= 1'b0;
            r_echo_prev <= 1'b0;
        end else begin
            r_echo_meta <= echo;
            r_echo_sync <= r_echo_meta;
            r_echo_prev <= r_echo_sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_width <= '0;
            r_pcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state != w_state_nxt) || (r_state == IDLE))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 32'd1;
            // The cycle the rise is seen is already the first high cycle.
            if (r_state == WAIT_RISE && w_rise)
                r_width <= 22'd1;
            else if (r_state == MEASURE && r_echo_sync && r_width != W_MAX)
                r_width <= r_width + 22'd1;
            if (r_state == IDLE && w_state_nxt == TRIG)
                r_pcnt <= '0;
            else if (r_pcnt != P_MAX)
                r_pcnt <= r_pcnt + 24'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dist  <= '0;
            r_tmo   <= 1'b0;
            r_new   <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_done) begin
                r_dist <= w_done_width;
                r_tmo  <= w_done_tmo;
            end
            // A completion in the same cycle as a DIST read keeps NEW set.
            if (r_state == HOLDOFF)
                r_new <= 1'b1;
            else if (w_bus_rd && s_address == 3'd0)
                r_new <= 1'b0;
            if (r_state == HOLDOFF)
                r_count <= r_count + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable   <= 1'b1;
            r_start    <= 1'b0;
            r_period   <= 24'(DEFAULT_PERIOD);
            r_readdata <= '0;
        end else begin
            r_start <= w_bus_wr && (s_address == 3'd1) && s_writedata[1];
            if (w_bus_wr && s_address == 3'd1)
                r_enable <= s_writedata[0];
            if (w_bus_wr && s_address == 3'd2)
                r_period <= s_writedata[23:0];
            if (w_bus_rd) begin
                case (s_address)
                    3'd0:    r_readdata <= {r_tmo, r_new, 8'd0, r_dist};
                    3'd1:    r_readdata <= {31'd0, r_enable};
                    3'd2:    r_readdata <= {8'd0, r_period};
                    3'd3:    r_readdata <= {16'd0, r_count};
                    default: r_readdata <= '0;
                endcase
            end
        end
    end
endmodule
